sha_256_ctrl: RTL and testbench
===============================

SHA_256_CTRL -- requirements
Module: sha_256_ctrl

Interface
REQ-001 SHALL have parameter none; block is fixed SHA-224/SHA-256, 32-bit input word, 512-bit block.
REQ-002 clk  input  1  clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 mode  input  1  0 = SHA-256, 1 = SHA-224; sampled with first accepted word of a message.
REQ-005 in_data  input  32  message word, big-endian (byte 0 in [31:24]).
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_last  input  1  word is final word of message.
REQ-008 in_bytes  input  2  valid bytes in last word, left-justified; 0 means 4.
REQ-009 in_ready  output  1  controller accepts word when in_valid and in_ready are both high.
REQ-010 core_block  output  512  block to hash core; W0 in [511:480], W15 in [31:0].
REQ-011 core_start  output  1  one-cycle pulse launching the core on core_block.
REQ-012 core_first  output  1  valid with core_start; 1 = core loads IV for core_mode, 0 = chain from previous hash.
REQ-013 core_mode  output  1  latched mode, valid with core_start.
REQ-014 core_hash  input  256  core result, valid while core_done is high.
REQ-015 core_done  input  1  one-cycle pulse: block finished.
REQ-016 digest  output  256  final hash; in SHA-224 mode [31:0] SHALL be zero.
REQ-017 digest_valid  output  1  digest available; held until accepted.
REQ-018 digest_ready  input  1  consumer accepts digest when digest_valid and digest_ready are both high.

Function
REQ-019 SHALL implement states IDLE, LOAD, PAD, LEN, ISSUE, WAIT, OUT.
REQ-020 IDLE: in_ready=1; accepted word -> store at index 0, latch mode, set first-block flag, go LOAD (or PAD if in_last).
REQ-021 LOAD: in_ready=1 while word index <16; one word per cycle; the 16th word of a block -> ISSUE next cycle with in_ready=0.
REQ-022 Bit length counter SHALL be 64 bits, add 8*(valid bytes) per accepted word, wrap mod 2^64.
REQ-023 On in_last with in_bytes=1..3: byte 0x80 at byte position in_bytes, lower bytes zero; with in_bytes=0: word stored intact, 0x80000000 written as next word in PAD.
REQ-024 PAD: write zero words one per cycle until index 14; if 0x80 landed at index 14 or 15, zero-fill to 16, ISSUE, then resume PAD on a fresh all-zero block.
REQ-025 LEN: W14=len[63:32], W15=len[31:0] written in one cycle, then ISSUE with final-block flag set.
REQ-026 ISSUE: core_start=1 for exactly one cycle, core_first = first-block flag, then clear flag; go WAIT.
REQ-027 WAIT: in_ready=0; on core_done store core_hash; if final block -> OUT, else if message words remain -> LOAD at index 0, else -> PAD at index 0.
REQ-028 core_done outside WAIT SHALL be ignored.
REQ-029 OUT: digest_valid=1, digest stable; on digest_ready -> IDLE next cycle, in_ready=1 in IDLE.
REQ-030 Block buffer SHALL be cleared to zero at each block start, so unwritten words read as zero.
REQ-031 Next message SHALL not be accepted before the current digest is handed off.

Reset
REQ-032 On rst=0 at a clock edge: state IDLE, in_ready=0 during the reset cycle, core_start=0, digest_valid=0, digest=0, core_block=0, length counter=0, flags cleared.
REQ-033 Reset mid-operation SHALL abort the message; a core_done arriving after reset SHALL be ignored.

Verification
REQ-034 SHA-256 "abc": one word 0x61626300, in_bytes=3, in_last -> single core_start, core_first=1, W0=0x61626380, W1..W14=0, W15=0x00000018; digest ba7816bf...f20015ad.
REQ-035 SHA-224 "abc" same stimulus, mode=1 -> core_mode=1, digest 23097d22...e36c9da7 in [255:32], [31:0]=0.
REQ-036 56-byte message (14 words, last in_bytes=0) -> two blocks: block 1 W14=0x80000000, W15=0; block 2 W0..W13=0, W15=0x000001C0, core_first 1 then 0.
REQ-037 64-byte message -> two blocks: block 2 W0=0x80000000, W15=0x00000200; in_ready low from 16th word until first core_done.
REQ-038 digest_ready held low 10 cycles in OUT -> digest_valid and digest stable, in_ready=0; release -> IDLE, next message accepted.
REQ-039 rst=0 while in WAIT, then spurious core_done -> state IDLE, digest_valid=0, no core_start, next "abc" produces correct digest.

Source files
------------

// File: rtl/sha_256_ctrl.sv
// SHA-224/256 message controller: packs 32-bit words into 512-bit blocks, appends
// padding and the 64-bit bit length, sequences an external compression core and holds the digest.
module sha_256_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         in_ready,
    output logic [511:0] core_block,
    output logic         core_start,
    output logic         core_first,
    output logic         core_mode,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PAD, S_LEN, S_ISSUE, S_WAIT, S_OUT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [511:0]  r_block;
    logic [4:0]    r_idx;
    logic [63:0]   r_len;
    logic          r_first;
    logic          r_final;
    logic          r_more;
    logic          r_pend;
    logic          r_mode;
    logic          r_core_start;
    logic          r_digest_valid;
    logic [255:0]  r_digest;

    logic          w_accept;
    logic [3:0]    w_widx;
    logic [5:0]    w_nbits;
    logic [31:0]   w_word;
    logic          w_full_last;

    // Final partial word: keep the valid bytes, put the 0x80 marker right after them.
    function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [1:0] nb);
        case (nb)
            2'd1:    pad_word = {d[31:24], 8'h80, 16'h0000};
            2'd2:    pad_word = {d[31:16], 8'h80, 8'h00};
            2'd3:    pad_word = {d[31:8], 8'h80};
            default: pad_word = d;
        endcase
    endfunction

    assign in_ready     = rst & ((r_state == S_IDLE) | ((r_state == S_LOAD) & (r_idx < 5'd16)));
    assign w_accept     = in_valid & in_ready;
    assign w_widx       = r_idx[3:0];
    assign w_nbits      = (in_bytes == 2'd0) ? 6'd32 : {1'b0, in_bytes, 3'b000};
    assign w_word       = pad_word(in_data, in_bytes);
    assign w_full_last  = in_last & (in_bytes == 2'd0);

    assign core_block   = r_block;
    assign core_start   = r_core_start;
    assign core_first   = r_first;
    assign core_mode    = r_mode;
    assign digest       = r_digest;
    assign digest_valid = r_digest_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; r_pend means the 0x80000000 marker word is still owed at r_idx
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = in_last ? S_PAD : S_LOAD;
                else          w_next = S_IDLE;
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (r_idx == 5'd15) w_next = S_ISSUE;
                    else if (in_last)   w_next = S_PAD;
                    else                w_next = S_LOAD;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_PAD: begin
                if (r_idx == 5'd16)                  w_next = S_ISSUE;
                else if ((r_idx == 5'd14) && !r_pend) w_next = S_LEN;
                else                                  w_next = S_PAD;
            end
            S_LEN:   w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    if (r_final)     w_next = S_OUT;
                    else if (r_more) w_next = S_LOAD;
                    else             w_next = S_PAD;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_OUT: begin
                if (digest_ready) w_next = S_IDLE;
                else              w_next = S_OUT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Block assembly, length counting, core handshake and digest capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_block        <= 512'h0;
            r_idx          <= 5'd0;
            r_len          <= 64'h0;
            r_first        <= 1'b0;
            r_final        <= 1'b0;
            r_more         <= 1'b0;
            r_pend         <= 1'b0;
            r_mode         <= 1'b0;
            r_core_start   <= 1'b0;
            r_digest_valid <= 1'b0;
            r_digest       <= 256'h0;
        end else begin
            r_core_start   <= (w_next == S_ISSUE);
            r_digest_valid <= (w_next == S_OUT);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_block <= {w_word, 480'h0};
                        r_idx   <= 5'd1;
                        r_len   <= {58'h0, w_nbits};
                        r_mode  <= mode;
                        r_first <= 1'b1;
                        r_final <= 1'b0;
                        r_more  <= 1'b0;
                        r_pend  <= w_full_last;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_block[{~w_widx, 5'b00000} +: 32] <= w_word;
                        r_idx  <= r_idx + 5'd1;
                        r_len  <= r_len + {58'h0, w_nbits};
                        r_pend <= w_full_last;
                        r_more <= ~in_last;
                    end
                end
                S_PAD: begin
                    if (w_next == S_PAD) begin
                        r_block[{~w_widx, 5'b00000} +: 32] <= r_pend ? 32'h8000_0000 : 32'h0;
                        r_pend <= 1'b0;
                        r_idx  <= r_idx + 5'd1;
                    end
                end
                S_LEN: begin
                    r_block[63:0] <= r_len;
                    r_final       <= 1'b1;
                end
                S_ISSUE: r_first <= 1'b0;
                S_WAIT: begin
                    if (core_done) begin
                        if (r_final) begin
                            r_digest <= r_mode ? {core_hash[255:32], 32'h0} : core_hash;
                        end else begin
                            r_block <= 512'h0;
                            r_idx   <= 5'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_256_ctrl.sv
// Bench for sha_256_ctrl: a behavioural SHA-256 core answers core_start, and a byte-level
// padding model predicts every block and the final digest of randomized messages.
module tb_sha_256_ctrl;
    typedef logic [7:0]   bytes_t[$];
    typedef logic [511:0] blks_t[$];

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mode = 1'b0;
    logic [31:0]  in_data = 32'h0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [1:0]   in_bytes = 2'd0;
    logic         in_ready;
    logic [511:0] core_block;
    logic         core_start;
    logic         core_first;
    logic         core_mode;
    logic [255:0] core_hash = 256'h0;
    logic         core_done = 1'b0;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sha_256_ctrl dut (
        .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
        .core_block(core_block), .core_start(core_start), .core_first(core_first),
        .core_mode(core_mode), .core_hash(core_hash), .core_done(core_done),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready)
    );

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] DIG_ABC_256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_ABC_224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] iv(input logic m);
        if (m) return 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
        else   return 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Standard message padding done on bytes: 0x80, zeros to 56 mod 64, 64-bit bit length.
    function automatic blks_t ref_blocks(input bytes_t msg);
        bytes_t p;
        blks_t q;
        logic [63:0] bl;
        logic [511:0] blk;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        for (int k = 0; k < p.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*k + j];
            q.push_back(blk);
        end
        return q;
    endfunction

    function automatic logic [255:0] ref_digest(input blks_t q, input logic m);
        logic [255:0] h;
        h = iv(m);
        foreach (q[i]) h = compress(h, q[i]);
        if (m) h[31:0] = 32'h0;
        return h;
    endfunction

    // Behavioural compression core: records every launch, answers three cycles later.
    int           resp_cnt = 0;
    int           done_cnt = 0;
    int           spur_tok = 0;
    int           spur_seen = 0;
    logic [255:0] chain = 256'h0;
    logic [511:0] obs_blk[$];
    logic         obs_first[$];
    logic         obs_mode[$];

    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst) begin
            resp_cnt = 0;
        end else begin
            if (spur_tok != spur_seen) begin
                spur_seen = spur_tok;
                core_done = 1'b1;
                core_hash = {8{32'hdeadbeef}};
            end else if (resp_cnt != 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    core_done = 1'b1;
                    core_hash = chain;
                    done_cnt++;
                end
            end
            if (core_start) begin
                obs_blk.push_back(core_block);
                obs_first.push_back(core_first);
                obs_mode.push_back(core_mode);
                chain = compress(core_first ? iv(core_mode) : chain, core_block);
                resp_cnt = 3;
            end
        end
    end

    task automatic send_msg(input bytes_t msg, input logic m, input int gap_pct);
        int nw;
        int tries;
        logic [31:0] w;
        nw = (msg.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            w = $urandom;
            for (int b = 0; b < 4; b++)
                if (4*i + b < msg.size()) w[31 - 8*b -: 8] = msg[4*i + b];
            in_data  = w;
            in_valid = 1'b1;
            in_last  = (i == nw - 1);
            in_bytes = (i == nw - 1) ? 2'(msg.size() % 4) : 2'd0;
            mode     = (i == 0) ? m : 1'($urandom);
            tries = 0;
            while (!in_ready && tries < 200) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 200) begin
                n_checks++; n_errors++;
                $display("FAIL send_timeout word %0d of %0d never accepted", i, nw);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 2'd0;
    endtask

    task automatic finish_msg(input bytes_t msg, input logic m, input int base, input int hold,
                              input string tag, output logic [255:0] got);
        blks_t exp_b;
        logic [255:0] exp_d;
        int tries;
        int nobs;
        logic stable;
        logic rdy_low;
        exp_b = ref_blocks(msg);
        exp_d = ref_digest(exp_b, m);
        got = 256'h0;
        tries = 0;
        while (!digest_valid && tries < 2000) begin
            @(negedge clk);
            tries++;
        end
        n_checks++;
        if (tries >= 2000) begin
            n_errors++;
            $display("FAIL %s digest_timeout digest_valid=%0b required 1", tag, digest_valid);
            return;
        end
        got = digest;
        if (hold > 0) begin
            stable = 1'b1;
            rdy_low = 1'b1;
            in_data = $urandom;
            in_valid = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (digest_valid !== 1'b1 || digest !== got) stable = 1'b0;
                if (in_ready !== 1'b0) rdy_low = 1'b0;
            end
            in_valid = 1'b0;
            n_checks++;
            if (stable !== 1'b1) begin
                n_errors++;
                $display("FAIL %s digest_hold stable=%0b required 1", tag, stable);
            end
            n_checks++;
            if (rdy_low !== 1'b1) begin
                n_errors++;
                $display("FAIL %s in_ready_in_out low=%0b required 1", tag, rdy_low);
            end
        end
        nobs = obs_blk.size() - base;
        n_checks++;
        if (nobs !== exp_b.size()) begin
            n_errors++;
            $display("FAIL %s block_count got %0d required %0d", tag, nobs, exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < nobs; i++) begin
            n_checks++;
            if (obs_blk[base + i] !== exp_b[i]) begin
                n_errors++;
                $display("FAIL %s block%0d got %h required %h", tag, i, obs_blk[base + i], exp_b[i]);
            end
            n_checks++;
            if (obs_first[base + i] !== (i == 0) || obs_mode[base + i] !== m) begin
                n_errors++;
                $display("FAIL %s flags%0d first=%0b mode=%0b required first=%0b mode=%0b",
                         tag, i, obs_first[base + i], obs_mode[base + i], (i == 0), m);
            end
        end
        n_checks++;
        if (got !== exp_d) begin
            n_errors++;
            $display("FAIL %s digest got %h required %h", tag, got, exp_d);
        end
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s handoff digest_valid=%0b in_ready=%0b required 0 1", tag, digest_valid, in_ready);
        end
    endtask

    task automatic run_msg(input bytes_t msg, input logic m, input int gap, input int hold,
                           input string tag, output logic [255:0] got, output int base);
        base = obs_blk.size();
        send_msg(msg, m, gap);
        finish_msg(msg, m, base, hold, tag, got);
    endtask

    function automatic bytes_t rand_msg(input int len);
        bytes_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || core_start !== 1'b0 || digest_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl in_ready=%0b core_start=%0b digest_valid=%0b required 0 0 0",
                     in_ready, core_start, digest_valid);
        end
        n_checks++;
        if (digest !== 256'h0 || core_block !== 512'h0) begin
            n_errors++;
            $display("FAIL reset_data digest=%h core_block=%h required 0", digest, core_block);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_idle in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_abc(input logic m, input string tag);
        bytes_t msg;
        logic [255:0] got;
        int base;
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, m, 0, 0, tag, got, base);
        n_checks++;
        if (obs_blk.size() <= base || obs_blk[base] !== {32'h61626380, 448'h0, 32'h00000018}) begin
            n_errors++;
            $display("FAIL %s abc_block observed blocks %0d, first differs from 61626380..00000018",
                     tag, obs_blk.size() - base);
        end
        n_checks++;
        if (got !== (m ? DIG_ABC_224 : DIG_ABC_256)) begin
            n_errors++;
            $display("FAIL %s abc_digest got %h required %h", tag, got, m ? DIG_ABC_224 : DIG_ABC_256);
        end
    endtask

    task automatic test_56byte();
        logic [255:0] got;
        int base;
        run_msg(rand_msg(56), 1'b0, 0, 0, "len56", got, base);
        n_checks++;
        if (obs_blk.size() < base + 2 || obs_blk[base][63:0] !== {32'h80000000, 32'h0} ||
            obs_blk[base + 1] !== {448'h0, 64'h1C0}) begin
            n_errors++;
            $display("FAIL len56_layout blocks=%0d required 2 with W14=80000000 then W15=1C0",
                     obs_blk.size() - base);
        end
    endtask

    task automatic test_64byte();
        bytes_t msg;
        logic [255:0] got;
        int base;
        int d0;
        int k;
        logic hi;
        msg = rand_msg(64);
        base = obs_blk.size();
        send_msg(msg, 1'b0, 20);
        d0 = done_cnt;
        hi = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 100) begin
            if (in_ready !== 1'b0) hi = 1'b1;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (hi !== 1'b0 || k >= 100) begin
            n_errors++;
            $display("FAIL len64_ready_gap in_ready_seen_high=%0b cycles=%0d required 0 and <100", hi, k);
        end
        finish_msg(msg, 1'b0, base, 0, "len64", got);
        n_checks++;
        if (obs_blk.size() < base + 2 || obs_blk[base + 1][511:480] !== 32'h80000000 ||
            obs_blk[base + 1][31:0] !== 32'h00000200) begin
            n_errors++;
            $display("FAIL len64_layout blocks=%0d required block2 W0=80000000 W15=200",
                     obs_blk.size() - base);
        end
    endtask

    task automatic test_backpressure();
        bytes_t msg;
        logic [255:0] got;
        int base;
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, 1'b0, 0, 10, "bp_hold", got, base);
        run_msg(msg, 1'b0, 0, 0, "bp_next", got, base);
        n_checks++;
        if (got !== DIG_ABC_256) begin
            n_errors++;
            $display("FAIL bp_next_digest got %h required %h", got, DIG_ABC_256);
        end
    endtask

    task automatic test_reset_in_wait();
        bytes_t msg;
        logic [255:0] got;
        int base;
        int t;
        logic bad;
        msg = '{8'h61, 8'h62, 8'h63};
        base = obs_blk.size();
        send_msg(msg, 1'b0, 0);
        t = 0;
        while (obs_blk.size() == base && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rstwait_ready in_ready=%0b required 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        spur_tok++;
        base = obs_blk.size();
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (digest_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0 || obs_blk.size() != base) begin
            n_errors++;
            $display("FAIL rstwait_idle bad=%0b new_starts=%0d required 0 0", bad, obs_blk.size() - base);
        end
        run_msg(msg, 1'b0, 0, 0, "rstwait_abc", got, base);
        n_checks++;
        if (got !== DIG_ABC_256) begin
            n_errors++;
            $display("FAIL rstwait_digest got %h required %h", got, DIG_ABC_256);
        end
    endtask

    task automatic test_random();
        logic [255:0] got;
        int base;
        for (int n = 0; n < 12; n++) begin
            run_msg(rand_msg($urandom_range(1, 140)), 1'($urandom), 25, $urandom_range(0, 3),
                    "random", got, base);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc(1'b0, "abc256");
        test_abc(1'b1, "abc224");
        test_56byte();
        test_64byte();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
